// File: rtl/synchronous_fifo.sv
// rtl/synchronous_fifo.sv - single-clock FIFO with full/empty flags and overflow/underflow reporting
// Optional macro SYNC_FIFO_STICKY_ERR_EN: overflow/underflow latch until reset instead of pulsing.
module synchronous_fifo #(
    parameter int WIDTH     = 8,
    parameter int FIFO_SIZE = 16,
    parameter int PTR       = $clog2(FIFO_SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             overflow,
    output logic             empty,
    output logic             underflow
);

    localparam logic [PTR:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [FIFO_SIZE];
    logic [PTR:0]     wr_ptr;
    logic [PTR:0]     rd_ptr;
    logic             wr_accept;
    logic             rd_accept;
    logic             overflow_set;
    logic             underflow_set;

    // Extra wrap bit distinguishes full (wrap bits differ) from empty (identical pointers).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR] != rd_ptr[PTR]) && (wr_ptr[PTR-1:0] == rd_ptr[PTR-1:0]);

    assign wr_accept     = wr_en & ~full;
    assign rd_accept     = rd_en & ~empty;
    assign overflow_set  = wr_en & full;
    assign underflow_set = rd_en & empty;

    // Storage is not cleared by reset; reset only blocks a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset && wr_accept) begin
            mem[wr_ptr[PTR-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rdata  <= mem[rd_ptr[PTR-1:0]];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
            overflow  <= overflow | overflow_set;
            underflow <= underflow | underflow_set;
`else
            overflow  <= overflow_set;
            underflow <= underflow_set;
`endif
        end
    end

endmodule

// File: tb/tb_synchronous_fifo.sv
// tb/tb_synchronous_fifo.sv - scoreboard bench for synchronous_fifo
module tb_synchronous_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             overflow;
    logic             empty;
    logic             underflow;

    synchronous_fifo #(.WIDTH(WIDTH), .FIFO_SIZE(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .full      (full),
        .overflow  (overflow),
        .empty     (empty),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int               pass_cnt = 0;
    int               total_cnt = 0;
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_rd = '0;
    logic             ovf_m = 1'b0;
    logic             unf_m = 1'b0;
    int               rd_issued = 0;
    int               rd_seen = 0;
    bit               mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops an expected word whenever a read was accepted, otherwise checks rdata holds.
    task automatic monitor();
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_seen != rd_issued) begin
                    rd_seen++;
                    if (exp_q.size() == 0) begin
                        check("rd_scoreboard_underrun", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", 32'(rdata), 32'(e));
                    end
                end else begin
                    check("rdata_hold", 32'(rdata), 32'(last_rd));
                end
            end
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        int   cnt;
        logic fm, em, wa, ra;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        wdata = d;
        cnt = mq.size();
        fm = (cnt == DEPTH);
        em = (cnt == 0);
        wa = w && !fm;
        ra = r && !em;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (ra) begin
            last_rd = mq.pop_front();
            exp_q.push_back(last_rd);
            rd_issued++;
        end
        if (wa) mq.push_back(d);
`ifdef SYNC_FIFO_STICKY_ERR_EN
        ovf_m = ovf_m | (w & fm);
        unf_m = unf_m | (r & em);
`else
        ovf_m = w & fm;
        unf_m = r & em;
`endif
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("underflow", 32'(underflow), 32'(unf_m));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        last_rd = '0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
    endtask

    initial begin
        int wn, rn, wg, rg, cyc;
        logic w, r;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        do_reset();
        mon_en = 1'b1;

        // FULL / OVERFLOW: 16 accepted writes, 17th rejected with a one-cycle pulse
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h3C + 8'(7 * i));
        check("full_after_16", 32'(full), 32'd1);
        check("empty_after_16", 32'(empty), 32'd0);
        check("no_overflow_16", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, 8'hEE);
        check("overflow_17th", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 8'h00);
`ifndef SYNC_FIFO_STICKY_ERR_EN
        check("overflow_one_cycle", 32'(overflow), 32'd0);
`endif
        check("full_held", 32'(full), 32'd1);

        // EMPTY / UNDERFLOW: drain 16 in order, 17th read rejected, rdata holds word 16
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        check("empty_after_drain", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check("underflow_17th", 32'(underflow), 32'd1);
        check("rdata_word16", 32'(rdata), 32'(8'h3C + 8'(7 * 15)));
        step(1'b0, 1'b0, 8'h00);

        // Simultaneous rd/wr: when empty, in the middle, and when full
        do_reset();
        step(1'b1, 1'b1, 8'h5A);
        check("simul_empty_underflow", 32'(underflow), 32'd1);
        step(1'b1, 1'b0, 8'h5B);
        step(1'b1, 1'b1, 8'h5C);
        for (int i = 0; i < DEPTH - 2; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
        check("simul_full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 8'h99);
        check("simul_full_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        check("wrap_drained", 32'(empty), 32'd1);

        // CONCURRENT: independent writer/reader with random 0-1 cycle gaps
        do_reset();
        wn = 0; rn = 0; wg = 0; rg = 0; cyc = 0;
        while ((wn < DEPTH || rn < DEPTH) && cyc < 400) begin
            w = (wn < DEPTH) && (wg == 0);
            r = (rn < DEPTH) && (rg == 0) && !empty;
            step(w, r, 8'hC0 + 8'(wn));
            if (w) begin wn++; wg = $urandom_range(0, 1); end
            else if (wg > 0) wg--;
            if (r) begin rn++; rg = $urandom_range(0, 1); end
            else if (rg > 0) rg--;
            cyc++;
        end
        check("concurrent_done", 32'(wn + rn), 32'(2 * DEPTH));
        check("concurrent_empty", 32'(empty), 32'd1);

        // RESET MID-OP
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        do_reset();
        step(1'b1, 1'b0, 8'hA7);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("reset_readback", 32'(rdata), 32'h0000_00A7);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("reads_checked", 32'(rd_seen), 32'(rd_issued));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
